// File: rtl/exc_commit_arb_pkg.sv
// Shared exception definitions for the commit-point arbiter: Ecode/EsubCode
// values, the WB exception flag bundle and the arbiter state encoding.
package exc_commit_arb_pkg;

  localparam logic [5:0] ECODE_INT       = 6'h00;
  localparam logic [5:0] ECODE_PIL       = 6'h01;
  localparam logic [5:0] ECODE_PIS       = 6'h02;
  localparam logic [5:0] ECODE_PIF       = 6'h03;
  localparam logic [5:0] ECODE_PME       = 6'h04;
  localparam logic [5:0] ECODE_PPI       = 6'h07;
  localparam logic [5:0] ECODE_ADEF_ADEM = 6'h08;
  localparam logic [5:0] ECODE_ALE       = 6'h09;
  localparam logic [5:0] ECODE_SYS       = 6'h0B;
  localparam logic [5:0] ECODE_BRK       = 6'h0C;
  localparam logic [5:0] ECODE_INE       = 6'h0D;
  localparam logic [5:0] ECODE_IPE       = 6'h0E;
  localparam logic [5:0] ECODE_TLBR      = 6'h3F;

  localparam logic [8:0] ESUB_ADEF = 9'd0;
  localparam logic [8:0] ESUB_ADEM = 9'd1;

  // Field order matches the wb_exc bus, MSB first.
  typedef struct packed {
    logic if_adef;
    logic if_tlbr;
    logic if_pif;
    logic if_ppi;
    logic id_ine;
    logic id_ipe;
    logic id_sys;
    logic id_brk;
    logic ex_ale;
    logic mem_adem;
    logic mem_tlbr;
    logic mem_pil_pis;
    logic mem_ppi_pme;
  } exc_flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/exc_commit_arb_prio_enc.sv
// Fixed-priority encoder turning interrupt-pending plus the WB exception flags
// into a single {valid, excode, esubcode, badv} exception descriptor.
module exc_prio_enc
  import exc_commit_arb_pkg::*;
(
  input  exc_flags_t  flags,
  input  logic        int_p,
  input  logic        is_store,
  input  logic        pme,
  input  logic [31:0] pc,
  input  logic [31:0] vaddr,
  output logic        valid,
  output logic [5:0]  excode,
  output logic [8:0]  esubcode,
  output logic [31:0] badv
);

  always_comb begin
    valid    = 1'b1;
    excode   = ECODE_INT;
    esubcode = ESUB_ADEF;
    badv     = 32'd0;
    // Interrupts carry no BADV; fetch faults report the PC, memory faults the vaddr.
    if (int_p) begin
      excode = ECODE_INT;
    end else if (flags.if_adef) begin
      excode = ECODE_ADEF_ADEM;
      badv   = pc;
    end else if (flags.if_tlbr) begin
      excode = ECODE_TLBR;
      badv   = pc;
    end else if (flags.if_pif) begin
      excode = ECODE_PIF;
      badv   = pc;
    end else if (flags.if_ppi) begin
      excode = ECODE_PPI;
      badv   = pc;
    end else if (flags.id_ine) begin
      excode = ECODE_INE;
    end else if (flags.id_ipe) begin
      excode = ECODE_IPE;
    end else if (flags.id_sys) begin
      excode = ECODE_SYS;
    end else if (flags.id_brk) begin
      excode = ECODE_BRK;
    end else if (flags.ex_ale) begin
      excode = ECODE_ALE;
      badv   = vaddr;
    end else if (flags.mem_adem) begin
      excode   = ECODE_ADEF_ADEM;
      esubcode = ESUB_ADEM;
      badv     = vaddr;
    end else if (flags.mem_tlbr) begin
      excode = ECODE_TLBR;
      badv   = vaddr;
    end else if (flags.mem_pil_pis) begin
      excode = is_store ? ECODE_PIS : ECODE_PIL;
      badv   = vaddr;
    end else if (flags.mem_ppi_pme) begin
      // PME is a store hitting a clean page; everything else is PPI.
      excode = (is_store && pme) ? ECODE_PME : ECODE_PPI;
      badv   = vaddr;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit_arb.sv
// Commit-point exception arbiter: picks one event per retiring WB instruction,
// pulses the CSR exception inputs once and holds flush until fetch redirects.
module exc_commit_arb
  import exc_commit_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic [12:0] wb_exc,
  input  logic        wb_is_store,
  input  logic        wb_pme,
  input  logic        wb_ertn,
  input  logic        wb_refetch,
  input  logic        ie,
  input  logic [11:0] lie,
  input  logic [11:0] is,
  input  logic        redirect_done,
  output logic        is_exc,
  output logic [5:0]  excode,
  output logic [8:0]  esubcode,
  output logic [31:0] badvaddr,
  output logic [31:0] csr_pc,
  output logic        is_ertn,
  output logic        is_fetch_again,
  output logic        flush,
  output logic        commit_ok
);

  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              int_p;
  logic              enc_valid;
  logic [5:0]        enc_excode;
  logic [8:0]        enc_esubcode;
  logic [31:0]       enc_badv;
  logic              take_exc;
  logic              take_evt;

  assign int_p = ie & (|(is & lie));

  exc_prio_enc u_prio_enc (
    .flags    (exc_flags_t'(wb_exc)),
    .int_p    (int_p),
    .is_store (wb_is_store),
    .pme      (wb_pme),
    .pc       (wb_pc),
    .vaddr    (wb_vaddr),
    .valid    (enc_valid),
    .excode   (enc_excode),
    .esubcode (enc_esubcode),
    .badv     (enc_badv)
  );

  // Events are only accepted in IDLE, i.e. never while flush is asserted.
  assign take_exc  = (state == IDLE) & wb_valid & enc_valid;
  assign take_evt  = (state == IDLE) & wb_valid & (enc_valid | wb_ertn | wb_refetch);
  assign commit_ok = (state == IDLE) & wb_valid & ~enc_valid;
  assign flush     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_evt) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (redirect_done || (wait_cnt == CNT_W'(MAX_WAIT))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state == ISSUE)  wait_cnt <= '0;
    else if (state == WAIT)       wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_exc         <= 1'b0;
      is_ertn        <= 1'b0;
      is_fetch_again <= 1'b0;
      excode         <= '0;
      esubcode       <= '0;
      badvaddr       <= '0;
      csr_pc         <= '0;
    end else if (take_evt) begin
      is_exc         <= take_exc;
      is_ertn        <= ~take_exc & wb_ertn;
      is_fetch_again <= ~take_exc & ~wb_ertn & wb_refetch;
      excode         <= take_exc ? enc_excode   : '0;
      esubcode       <= take_exc ? enc_esubcode : '0;
      badvaddr       <= take_exc ? enc_badv     : '0;
      csr_pc         <= wb_pc;
    end else begin
      // Outside the ISSUE cycle the CSR must see no pulse and no stale code.
      is_exc         <= 1'b0;
      is_ertn        <= 1'b0;
      is_fetch_again <= 1'b0;
      excode         <= '0;
    end
  end

endmodule
